// File: rtl/gtp_link_pkg.sv
// Shared definitions for the inter-FPGA GTP link framers (transmit and receive).
// Holds the comma characters, the word formats and the framer state encoding.
package gtp_link_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [7:0]  K28_1     = 8'h3C;
  localparam logic [15:0] IDLE_WORD = {K28_1, K28_5};

  localparam logic [1:0]  CHARISK_HDR  = 2'b01;
  localparam logic [1:0]  CHARISK_DATA = 2'b00;
  localparam logic [1:0]  CHARISK_IDLE = 2'b11;

  // Header word plus four data words; each word carries one payload byte.
  localparam int FRAME_WORDS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } framer_state_t;

endpackage

// File: rtl/gtp_tx_frame_buf.sv
// Two-slot frame buffer for the transmit framer. Upstream bytes fill one
// 5-byte slot at a time; the framer reads a full slot byte by byte and
// releases it after the last word, which hands the slot back to the writer.
module gtp_tx_frame_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] rd_idx,
  input  logic       rd_release,
  output logic [7:0] rd_byte,
  output logic       rd_full
);
  import gtp_link_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(FRAME_WORDS - 1);

  logic [7:0] mem [2][FRAME_WORDS];
  logic [1:0] full;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;
  logic       wr_slot;
  logic       rd_slot;
  logic [2:0] wr_idx;
  logic       wr_fire;
  logic       wr_last;

  // The writer only ever targets an empty slot, so it cannot disturb the
  // slot the framer is reading (that one is always full).
  assign wr_ready = !reset && !full[wr_slot];
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_last  = (wr_idx == LAST_IDX);
  assign rd_byte  = mem[rd_slot][rd_idx];
  assign rd_full  = full[rd_slot];

  // Work out which full flags get set by a completed slot and cleared by a release.
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (wr_fire && wr_last) set_mask[wr_slot] = 1'b1;
    if (rd_release)         clr_mask[rd_slot] = 1'b1;
  end

  // Payload storage; contents are only meaningful once the slot is marked full.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_slot][wr_idx] <= wr_data;
  end

  // Pointer and full-flag bookkeeping; a fill and a release in one cycle hit different slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 2'b00;
      wr_slot <= 1'b0;
      rd_slot <= 1'b0;
      wr_idx  <= 3'd0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_idx  <= 3'd0;
          wr_slot <= ~wr_slot;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end
      if (rd_release) rd_slot <= ~rd_slot;
      full <= (full | set_mask) & ~clr_mask;
    end
  end

endmodule

// File: rtl/gtp_tx_framer.sv
// Transmit framer for the inter-FPGA GTP link. Turns buffered 5-byte frames
// into a comma-marked header word plus four data words, with idle words
// (never a lone K28.5 in the low byte) filling every gap between frames.
module gtp_tx_framer #(
  parameter int         MIN_IDLE  = 1,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        gt_txusrclk_in,
  input  logic        reset_in,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  COMMUNICATE_BTW_FPGA,
  output logic [15:0] gt_txdata,
  output logic [1:0]  gt_txcharisk,
  output logic        tx_busy
);
  import gtp_link_pkg::*;

  localparam logic [3:0] GAP_TARGET = 4'(MIN_IDLE);
  localparam logic [2:0] LAST_WORD  = 3'(FRAME_WORDS - 1);

  framer_state_t state;
  logic [2:0]    word_cnt;
  logic [3:0]    gap_cnt;
  logic          gap_done;
  logic [7:0]    rd_byte;
  logic          rd_full;
  logic          rd_release;
  logic          start;
  logic          ctrl_unused;

  // Only bit 0 of the link control word means anything to the transmitter.
  assign ctrl_unused = ^COMMUNICATE_BTW_FPGA[3:1];

  // gap_done tracks "gap counter has reached MIN_IDLE", so the start test
  // needs no magnitude compare against a possibly-zero constant.
  assign start      = (state == IDLE) && rd_full && COMMUNICATE_BTW_FPGA[0] && gap_done;
  assign rd_release = (state == DATA) && (word_cnt == LAST_WORD);

  gtp_tx_frame_buf u_buf (
    .clk        (gt_txusrclk_in),
    .reset      (reset_in),
    .wr_data    (tx_data),
    .wr_valid   (tx_valid),
    .wr_ready   (tx_ready),
    .rd_idx     (word_cnt),
    .rd_release (rd_release),
    .rd_byte    (rd_byte),
    .rd_full    (rd_full)
  );

  // Framer FSM with registered GTP outputs. After the last data word it
  // always returns to IDLE; with MIN_IDLE = 0 that IDLE cycle already loads
  // the next header, so back-to-back frames carry no idle word in between.
  always_ff @(posedge gt_txusrclk_in) begin
    if (reset_in) begin
      state        <= IDLE;
      word_cnt     <= 3'd0;
      gap_cnt      <= GAP_TARGET;
      gap_done     <= 1'b1;
      gt_txdata    <= IDLE_WORD;
      gt_txcharisk <= CHARISK_IDLE;
      tx_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gt_txdata    <= {rd_byte, K28_5};
            gt_txcharisk <= CHARISK_HDR;
            tx_busy      <= 1'b1;
            word_cnt     <= 3'd1;
            state        <= DATA;
          end else begin
            gt_txdata    <= IDLE_WORD;
            gt_txcharisk <= CHARISK_IDLE;
            tx_busy      <= 1'b0;
            if (!gap_done) begin
              gap_cnt  <= gap_cnt + 4'd1;
              gap_done <= ((gap_cnt + 4'd1) == GAP_TARGET);
            end
          end
        end
        DATA: begin
          gt_txdata    <= {rd_byte, FILL_BYTE};
          gt_txcharisk <= CHARISK_DATA;
          tx_busy      <= 1'b1;
          if (word_cnt == LAST_WORD) begin
            word_cnt <= 3'd0;
            gap_cnt  <= 4'd0;
            gap_done <= (GAP_TARGET == 4'd0);
            state    <= IDLE;
          end else begin
            word_cnt <= word_cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Self-checking bench for gtp_tx_framer: a MIN_IDLE=1 instance for most
// scenarios and a MIN_IDLE=0 instance for back-to-back frames. A monitor
// decodes the GTP word stream and pops expected payload from a scoreboard.
module tb_gtp_tx_framer;

  localparam logic [7:0] FILL = 8'h00;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  isk;
    logic        busy;
  } word_vec_t;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [7:0]  tx_data, tx_data_z;
  logic        tx_valid, tx_valid_z;
  logic        tx_ready, tx_ready_z;
  logic [3:0]  comm, comm_z;
  logic [15:0] gt_txdata, gt_txdata_z;
  logic [1:0]  gt_txcharisk, gt_txcharisk_z;
  logic        tx_busy, tx_busy_z;

  int          vec_count   = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [7:0]  sb[$];
  int          hdr_times[$];
  bit          mon_en   = 1'b0;
  bit          in_frame = 1'b0;
  int          word_idx = 0;
  word_vec_t   single_vec [8];

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp headers.
  always @(posedge clk) cyc++;

  gtp_tx_framer #(.MIN_IDLE(1), .FILL_BYTE(FILL)) dut (
    .gt_txusrclk_in       (clk),
    .reset_in             (reset_in),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .COMMUNICATE_BTW_FPGA (comm),
    .gt_txdata            (gt_txdata),
    .gt_txcharisk         (gt_txcharisk),
    .tx_busy              (tx_busy)
  );

  gtp_tx_framer #(.MIN_IDLE(0), .FILL_BYTE(FILL)) dut_z (
    .gt_txusrclk_in       (clk),
    .reset_in             (reset_in),
    .tx_data              (tx_data_z),
    .tx_valid             (tx_valid_z),
    .tx_ready             (tx_ready_z),
    .COMMUNICATE_BTW_FPGA (comm_z),
    .gt_txdata            (gt_txdata_z),
    .gt_txcharisk         (gt_txcharisk_z),
    .tx_busy              (tx_busy_z)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkByte(input logic [7:0] b);
    if (sb.size() == 0) checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
    else                checkOutput("payload", 32'(b), 32'(sb.pop_front()));
  endtask

  // Offer one byte until accepted; the scoreboard records it on acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    #1;
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (tx_ready) sb.push_back(b);
    else          checkOutput("push_timeout", 32'(tx_ready), 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_in   = 1'b1;
    tx_valid   = 1'b0;
    tx_valid_z = 1'b0;
    comm       = 4'h0;
    comm_z     = 4'h0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    sb.delete();
    hdr_times.delete();
    in_frame = 1'b0;
    word_idx = 0;
  endtask

  // Receiver model: decode headers/data/idle and compare payload against the scoreboard.
  always @(negedge clk) begin
    if (reset_in) begin
      in_frame = 1'b0;
      word_idx = 0;
    end else if (mon_en) begin
      checkOutput("mon_busy", 32'(tx_busy), 32'(gt_txcharisk != 2'b11));
      case (gt_txcharisk)
        2'b01: begin
          checkOutput("hdr_k28_5", 32'(gt_txdata[7:0]), 32'hBC);
          if (in_frame) checkOutput("frame_len", 32'(word_idx), 32'd5);
          checkByte(gt_txdata[15:8]);
          hdr_times.push_back(cyc);
          in_frame = 1'b1;
          word_idx = 1;
        end
        2'b00: begin
          checkOutput("data_in_frame", 32'(in_frame), 32'd1);
          checkOutput("data_fill", 32'(gt_txdata[7:0]), 32'(FILL));
          checkByte(gt_txdata[15:8]);
          word_idx++;
          if (word_idx == 5) in_frame = 1'b0;
        end
        2'b11: begin
          checkOutput("idle_word", 32'(gt_txdata), 32'h3CBC);
          if (in_frame) begin
            checkOutput("frame_len", 32'(word_idx), 32'd5);
            in_frame = 1'b0;
          end
        end
        default: checkOutput("charisk_legal", 32'(gt_txcharisk), 32'h3);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int w;
    int busy_cnt;
    logic [7:0]  b;
    logic [15:0] exp_d;
    logic [1:0]  exp_k;

    single_vec[0] = '{16'h3CBC, 2'b11, 1'b0};
    single_vec[1] = '{16'h11BC, 2'b01, 1'b1};
    single_vec[2] = '{16'h2200, 2'b00, 1'b1};
    single_vec[3] = '{16'h3300, 2'b00, 1'b1};
    single_vec[4] = '{16'h4400, 2'b00, 1'b1};
    single_vec[5] = '{16'h5500, 2'b00, 1'b1};
    single_vec[6] = '{16'h3CBC, 2'b11, 1'b0};
    single_vec[7] = '{16'h3CBC, 2'b11, 1'b0};

    reset_in = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; comm = 4'h0;
    tx_data_z = 8'h00; tx_valid_z = 1'b0; comm_z = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_txdata", 32'(gt_txdata), 32'h3CBC);
    checkOutput("rst_charisk", 32'(gt_txcharisk), 32'h3);
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_ready_z", 32'(tx_ready_z), 32'd0);
    reset_in = 1'b0;
    #1;
    checkOutput("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single frame, exact cycle-by-cycle output
    $display("[TB] single frame");
    mon_en = 1'b1;
    comm   = 4'h1;
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h44); applyStimulus(8'h55);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checkOutput("single_data", 32'(gt_txdata), 32'(single_vec[i].data));
      checkOutput("single_isk", 32'(gt_txcharisk), 32'(single_vec[i].isk));
      checkOutput("single_busy", 32'(tx_busy), 32'(single_vec[i].busy));
    end

    // Back-pressure: 15 bytes with valid held high, link disabled at first
    $display("[TB] back-pressure");
    doReset();
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      tx_data  = 8'(8'h60 + acc);
      tx_valid = 1'b1;
      #1;
      if (tx_ready) begin sb.push_back(tx_data); acc++; end
    end
    checkOutput("bp_accepted", 32'(acc), 32'd10);
    checkOutput("bp_ready_low", 32'(tx_ready), 32'd0);
    checkOutput("bp_gated_idle", 32'(gt_txcharisk), 32'h3);
    comm = 4'h1;
    for (int c = 0; c < 100 && acc < 15; c++) begin
      @(negedge clk);
      tx_data  = 8'(8'h60 + acc);
      tx_valid = 1'b1;
      #1;
      if (tx_ready) begin sb.push_back(tx_data); acc++; end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("bp_all_accepted", 32'(acc), 32'd15);
    w = 0;
    while (hdr_times.size() < 3 && w < 100) begin @(negedge clk); w++; end
    repeat (8) @(negedge clk);
    checkOutput("bp_frames", 32'(hdr_times.size()), 32'd3);
    if (hdr_times.size() >= 3) begin
      checkOutput("bp_spacing_12", 32'(hdr_times[1] - hdr_times[0]), 32'd6);
      checkOutput("bp_spacing_23", 32'(hdr_times[2] - hdr_times[1]), 32'd6);
    end
    checkOutput("bp_drained", 32'(sb.size()), 32'd0);

    // Enable gating: held off while disabled, header one cycle after enable
    $display("[TB] enable gating");
    doReset();
    comm = 4'hE;
    applyStimulus(8'h5A); applyStimulus(8'h5B); applyStimulus(8'h5C);
    applyStimulus(8'h5D); applyStimulus(8'h5E);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("gate_idle", 32'(gt_txcharisk), 32'h3);
    end
    comm = 4'h1;
    @(negedge clk);
    checkOutput("gate_hdr", 32'(gt_txdata), 32'h5ABC);
    checkOutput("gate_hdr_isk", 32'(gt_txcharisk), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_d = (i < 5) ? {8'(8'h5A + i), FILL} : 16'h3CBC;
      exp_k = (i < 5) ? 2'b00 : 2'b11;
      checkOutput("gate_word", 32'(gt_txdata), 32'(exp_d));
      checkOutput("gate_word_isk", 32'(gt_txcharisk), 32'(exp_k));
      if (i == 2) comm = 4'hE;
    end

    // MIN_IDLE = 0: two full slots go out back to back
    $display("[TB] back-to-back frames");
    doReset();
    acc = 0;
    for (int c = 0; c < 40 && acc < 10; c++) begin
      @(negedge clk);
      tx_data_z  = 8'(8'hA0 + acc);
      tx_valid_z = 1'b1;
      #1;
      if (tx_ready_z) acc++;
    end
    @(negedge clk);
    tx_valid_z = 1'b0;
    checkOutput("z_accepted", 32'(acc), 32'd10);
    comm_z = 4'h1;
    w = 0;
    while (gt_txcharisk_z != 2'b01 && w < 20) begin @(negedge clk); w++; end
    checkOutput("z_hdr_seen", 32'(gt_txcharisk_z), 32'h1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      b = 8'(8'hA0 + i);
      if (i == 10)         begin exp_d = 16'h3CBC;    exp_k = 2'b11; end
      else if (i % 5 == 0) begin exp_d = {b, 8'hBC};  exp_k = 2'b01; end
      else                 begin exp_d = {b, FILL};   exp_k = 2'b00; end
      checkOutput("z_word", 32'(gt_txdata_z), 32'(exp_d));
      checkOutput("z_isk", 32'(gt_txcharisk_z), 32'(exp_k));
      checkOutput("z_busy", 32'(tx_busy_z), 32'(i < 10));
    end

    // Reset during data word 3 aborts the frame and discards the buffer
    $display("[TB] reset mid-frame");
    doReset();
    mon_en = 1'b0;
    applyStimulus(8'hE1); applyStimulus(8'hE2); applyStimulus(8'hE3);
    applyStimulus(8'hE4); applyStimulus(8'hE5);
    applyStimulus(8'hF1); applyStimulus(8'hF2); applyStimulus(8'hF3);
    @(negedge clk);
    tx_valid = 1'b0;
    comm = 4'h1;
    w = 0;
    while (gt_txcharisk != 2'b01 && w < 20) begin @(negedge clk); w++; end
    checkOutput("rm_hdr", 32'(gt_txdata), 32'hE1BC);
    repeat (3) @(negedge clk);
    checkOutput("rm_word3", 32'(gt_txdata), 32'hE400);
    reset_in = 1'b1;
    @(negedge clk);
    checkOutput("rm_idle", 32'(gt_txdata), 32'h3CBC);
    checkOutput("rm_idle_isk", 32'(gt_txcharisk), 32'h3);
    checkOutput("rm_busy", 32'(tx_busy), 32'd0);
    checkOutput("rm_ready_in_rst", 32'(tx_ready), 32'd0);
    reset_in = 1'b0;
    #1;
    checkOutput("rm_ready_after", 32'(tx_ready), 32'd1);
    busy_cnt = 0;
    repeat (20) begin @(negedge clk); if (tx_busy) busy_cnt++; end
    checkOutput("rm_no_replay", 32'(busy_cnt), 32'd0);
    sb.delete();
    in_frame = 1'b0;
    mon_en   = 1'b1;
    applyStimulus(8'hC1); applyStimulus(8'hC2); applyStimulus(8'hC3);
    applyStimulus(8'hC4); applyStimulus(8'hC5);
    @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 30) begin @(negedge clk); w++; end
    checkOutput("rm_fresh_drained", 32'(sb.size()), 32'd0);

    // Loopback through the receiver model: 100 random frames, random gaps
    $display("[TB] random frames");
    doReset();
    mon_en = 1'b1;
    comm   = 4'h1;
    for (int f = 0; f < 100; f++) begin
      for (int j = 0; j < 5; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          tx_valid = 1'b0;
        end
        applyStimulus(8'($urandom));
      end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while ((sb.size() != 0 || in_frame) && w < 100) begin @(negedge clk); w++; end
    checkOutput("loop_drained", 32'(sb.size()), 32'd0);
    checkOutput("loop_frames", 32'(hdr_times.size()), 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
